sr04_scan_scheduler: RTL and testbench

- Time-multiplexed ranging controller for up to CH_NUM HC-SR04 ultrasonic sensors.
- Fires one sensor at a time: TRIG pulse, echo-width timing, conversion to millimetres, then a guard gap to suppress acoustic crosstalk.
- Channels are visited round-robin under an enable mask.
- Results go to the UART packer / flight logic as (channel, distance, timeout) with a one-cycle ready strobe.

---
 rtl/sr04_pkg.sv | 24 ++
 rtl/sr04_us_tick.sv | 28 ++
 rtl/sr04_scan_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sr04_scan_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared types and constants for the SR04 scan scheduler.
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_CALC,
    ST_RESULT,
    ST_GUARD
  } sr04_state_e;

  // mm = ticks * 0.17149, done as a 16.16 fixed-point multiply.
  localparam logic [15:0] SR04_MM_SCALE = 16'd11239;
  localparam int          SR04_MM_SHIFT = 16;
  localparam logic [15:0] SR04_TMO_DIST = 16'hFFFF;

  // Wraps an index that is known to be below 2*n back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/sr04_us_tick.sv
// Free-running divider: one-cycle tick every CLK_PER_US clocks.
module sr04_us_tick #(
  parameter int CLK_PER_US = 50
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sr04_scan_scheduler.sv
// Round-robin HC-SR04 ranging controller: trigger, echo timing, mm conversion, guard gap.
// Defining SR04_SCAN_DONE_EN adds a SCAN_DONE output marking the last channel of each round.
module sr04_scan_scheduler
  import sr04_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int CLK_PER_US   = 50,
  parameter int TRIG_US      = 10,
  parameter int RISE_WAIT_US = 1000,
  parameter int ECHO_MAX_US  = 30000,
  parameter int GUARD_US     = 10000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [CH_NUM-1:0] CH_MASK,
  input  logic [CH_NUM-1:0] ECHO,
  output logic [CH_NUM-1:0] TRIG,
  output logic [15:0]       DIST_MM,
  output logic [2:0]        CH_ID,
  output logic              TMO,
  output logic              DAT_RDY,
  output logic              BUSY
`ifdef SR04_SCAN_DONE_EN
  ,
  output logic              SCAN_DONE
`endif
);

  localparam int PW = $clog2(CH_NUM);
  localparam logic [15:0] TRIG_LIM  = 16'(TRIG_US - 1);
  localparam logic [15:0] RISE_LIM  = 16'(RISE_WAIT_US - 1);
  localparam logic [15:0] GUARD_LIM = 16'(GUARD_US - 1);
  localparam logic [15:0] ECHO_LIM  = 16'(ECHO_MAX_US);

  sr04_state_e state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, rr_next;
  logic          rr_found;
  logic [15:0]   tmr, tmr_nxt, echo_cnt, echo_cnt_nxt;
  logic [CH_NUM-1:0] echo_s1, echo_s2;
  logic          echo_sel, echo_prev, echo_rise;
  logic          us_tick;
  logic [31:0]   product;
  logic [15:0]   res_dist;
  logic          res_tmo;
  logic          ld_result;

  sr04_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (us_tick)
  );

  // Echo prev is forced low while triggering so an echo already high counts as a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_prev <= 1'b0;
    end else begin
      echo_s1   <= ECHO;
      echo_s2   <= echo_s1;
      echo_prev <= (state == ST_TRIG) ? 1'b0 : echo_sel;
    end
  end

  assign echo_sel  = echo_s2[ptr];
  assign echo_rise = echo_sel & ~echo_prev;
  assign product   = 32'(echo_cnt) * 32'(SR04_MM_SCALE);

  always_comb begin
    rr_found = 1'b0;
    rr_next  = ptr;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!rr_found && CH_MASK[rr_wrap(int'(ptr) + i, CH_NUM)]) begin
        rr_found = 1'b1;
        rr_next  = PW'(rr_wrap(int'(ptr) + i, CH_NUM));
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    echo_cnt_nxt = echo_cnt;
    res_dist     = SR04_TMO_DIST;
    res_tmo      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (EN && rr_found) begin
          ptr_nxt   = rr_next;
          state_nxt = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (us_tick && tmr == TRIG_LIM) state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          echo_cnt_nxt = '0;
          state_nxt    = ST_MEASURE;
        end else if (us_tick && tmr == RISE_LIM) begin
          state_nxt = ST_RESULT;
        end
      end
      ST_MEASURE: begin
        if (!echo_sel) begin
          state_nxt = ST_CALC;
        end else if (us_tick) begin
          if (echo_cnt != 16'hFFFF) echo_cnt_nxt = echo_cnt + 16'd1;
          if (echo_cnt_nxt >= ECHO_LIM) state_nxt = ST_RESULT;
        end
      end
      ST_CALC: begin
        res_dist  = 16'(product >> SR04_MM_SHIFT);
        res_tmo   = 1'b0;
        state_nxt = ST_RESULT;
      end
      ST_RESULT: state_nxt = ST_GUARD;
      ST_GUARD: begin
        if (us_tick && tmr == GUARD_LIM) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every state timer restarts from zero on entry.
  always_comb begin
    tmr_nxt = tmr;
    if (state_nxt != state) tmr_nxt = '0;
    else if (us_tick)       tmr_nxt = tmr + 16'd1;
  end

  assign ld_result = (state_nxt == ST_RESULT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      ptr      <= PW'(CH_NUM - 1);
      tmr      <= '0;
      echo_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      tmr      <= tmr_nxt;
      echo_cnt <= echo_cnt_nxt;
    end
  end

  // Result outputs load on entry to RESULT so DAT_RDY covers exactly that cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DIST_MM <= '0;
      CH_ID   <= '0;
      TMO     <= 1'b0;
      DAT_RDY <= 1'b0;
    end else begin
      DAT_RDY <= ld_result;
      if (ld_result) begin
        DIST_MM <= res_dist;
        TMO     <= res_tmo;
        CH_ID   <= 3'(ptr);
      end
    end
  end

  always_comb begin
    TRIG = '0;
    if (state == ST_TRIG) TRIG[ptr] = 1'b1;
  end

  assign BUSY = (state != ST_IDLE);

`ifdef SR04_SCAN_DONE_EN
  logic [PW-1:0] mask_hi, last_hi;

  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (CH_MASK[i]) mask_hi = PW'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_hi   <= '0;
      SCAN_DONE <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_TRIG) last_hi <= mask_hi;
      SCAN_DONE <= ld_result && (ptr == last_hi);
    end
  end
`endif

endmodule

// File: tb/tb_sr04_scan_scheduler.sv
// Directed bench for sr04_scan_scheduler with time constants scaled down (2 clocks per us).
module tb_sr04_scan_scheduler;

  localparam int CPU      = 2;
  localparam int TRIG_T   = 10;
  localparam int RISE_T   = 100;
  localparam int ECHO_T   = 6000;
  localparam int GUARD_T  = 300;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] CH_MASK = '0;
  logic [3:0] ECHO = '0;
  logic [3:0] TRIG;
  logic [15:0] DIST_MM;
  logic [2:0] CH_ID;
  logic       TMO, DAT_RDY, BUSY;
`ifdef SR04_SCAN_DONE_EN
  logic       SCAN_DONE;
`endif

  int vectors = 0;
  int miscompares = 0;

  sr04_scan_scheduler #(
    .CH_NUM(4), .CLK_PER_US(CPU), .TRIG_US(TRIG_T), .RISE_WAIT_US(RISE_T),
    .ECHO_MAX_US(ECHO_T), .GUARD_US(GUARD_T)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_MASK(CH_MASK), .ECHO(ECHO),
    .TRIG(TRIG), .DIST_MM(DIST_MM), .CH_ID(CH_ID), .TMO(TMO),
    .DAT_RDY(DAT_RDY), .BUSY(BUSY)
`ifdef SR04_SCAN_DONE_EN
    , .SCAN_DONE(SCAN_DONE)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_reset();
    RST = 1'b1; EN = 1'b0; CH_MASK = '0; ECHO = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_trig_rise(input int budget, output int ch, output int cycles);
    cycles = 0;
    while (TRIG == 4'b0 && cycles < budget) begin
      @(negedge CLK);
      cycles++;
    end
    ch = -1;
    if ($countones(TRIG) > 1) ch = -2;
    else for (int i = 0; i < 4; i++) if (TRIG[i]) ch = i;
  endtask

  task automatic wait_trig_fall(input int budget, output int width);
    width = 0;
    while (TRIG != 4'b0 && width < budget) begin
      @(negedge CLK);
      width++;
    end
  endtask

  task automatic wait_rdy(input int budget, output bit got, output int cycles);
    cycles = 0;
    while (!DAT_RDY && cycles < budget) begin
      @(negedge CLK);
      cycles++;
    end
    got = DAT_RDY;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (TRIG !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_trig: got %b want 0000", TRIG); end
    vectors++;
    if (DIST_MM !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_dist: got %0d want 0", DIST_MM); end
    vectors++;
    if (CH_ID !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_chid: got %0d want 0", CH_ID); end
    vectors++;
    if (TMO !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tmo: got %b want 0", TMO); end
    vectors++;
    if (DAT_RDY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b want 0", DAT_RDY); end
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_basic_measure();
    int ch, cyc, width;
    bit got;
    apply_reset();
    CH_MASK = 4'b1111; EN = 1'b1;
    wait_trig_rise(100, ch, cyc);
    vectors++;
    if (ch !== 0) begin miscompares++; $display("[TB] FAIL basic_first_ch: got %0d want 0", ch); end
    wait_trig_fall(100, width);
    vectors++;
    if (width < 2*TRIG_T - 2 || width > 2*TRIG_T) begin
      miscompares++; $display("[TB] FAIL basic_trig_width: got %0d cycles want %0d..%0d", width, 2*TRIG_T-2, 2*TRIG_T);
    end
    ECHO[0] = 1'b1;
    repeat (5000*CPU) @(negedge CLK);
    ECHO[0] = 1'b0;
    wait_rdy(50, got, cyc);
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_rdy: got %b want 1", got); end
    vectors++;
    if (CH_ID !== 3'd0) begin miscompares++; $display("[TB] FAIL basic_chid: got %0d want 0", CH_ID); end
    vectors++;
    if (DIST_MM < 16'd856 || DIST_MM > 16'd858) begin miscompares++; $display("[TB] FAIL basic_dist: got %0d want 857+-1", DIST_MM); end
    vectors++;
    if (TMO !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_tmo: got %b want 0", TMO); end
    @(negedge CLK);
    vectors++;
    if (DAT_RDY !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_rdy_width: got %b want 0", DAT_RDY); end
    wait_trig_rise(2*CPU*GUARD_T, ch, cyc);
    cyc = cyc + 1;
    vectors++;
    if (ch !== 1) begin miscompares++; $display("[TB] FAIL basic_next_ch: got %0d want 1", ch); end
    vectors++;
    if (cyc < CPU*GUARD_T - 2 || cyc > CPU*GUARD_T + 10) begin
      miscompares++; $display("[TB] FAIL basic_guard: got %0d cycles want %0d..%0d", cyc, CPU*GUARD_T-2, CPU*GUARD_T+10);
    end
    vectors++;
    if (DIST_MM < 16'd856 || DIST_MM > 16'd858) begin miscompares++; $display("[TB] FAIL basic_dist_hold: got %0d want 857+-1", DIST_MM); end
  endtask

  task automatic test_timeout_alternate();
    int exp_ch[3] = '{1, 3, 1};
    int ch, cyc, width;
    bit got;
    apply_reset();
    CH_MASK = 4'b1010; EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_trig_rise(2*CPU*GUARD_T, ch, cyc);
      vectors++;
      if (ch !== exp_ch[k]) begin miscompares++; $display("[TB] FAIL alt_ch%0d: got %0d want %0d", k, ch, exp_ch[k]); end
      wait_trig_fall(100, width);
      wait_rdy(2*CPU*RISE_T, got, cyc);
      vectors++;
      if (got !== 1'b1 || cyc < CPU*RISE_T - 4 || cyc > CPU*RISE_T + 6) begin
        miscompares++; $display("[TB] FAIL alt_latency%0d: got rdy=%b after %0d cycles want ~%0d", k, got, cyc, CPU*RISE_T);
      end
      vectors++;
      if (DIST_MM !== 16'hFFFF || TMO !== 1'b1 || CH_ID !== 3'(exp_ch[k])) begin
        miscompares++; $display("[TB] FAIL alt_result%0d: got dist=%h tmo=%b ch=%0d want FFFF 1 %0d", k, DIST_MM, TMO, CH_ID, exp_ch[k]);
      end
`ifdef SR04_SCAN_DONE_EN
      vectors++;
      if (SCAN_DONE !== (exp_ch[k] == 3)) begin
        miscompares++; $display("[TB] FAIL alt_scan_done%0d: got %b want %b", k, SCAN_DONE, exp_ch[k] == 3);
      end
`endif
      @(negedge CLK);
    end
  endtask

  task automatic test_stuck_high();
    int ch, cyc, width;
    bit got;
    apply_reset();
    ECHO = 4'b0100; CH_MASK = 4'b0100; EN = 1'b1;
    wait_trig_rise(100, ch, cyc);
    vectors++;
    if (ch !== 2) begin miscompares++; $display("[TB] FAIL stuck_ch: got %0d want 2", ch); end
    wait_trig_fall(100, width);
    wait_rdy(2*CPU*ECHO_T, got, cyc);
    vectors++;
    if (got !== 1'b1 || cyc < CPU*ECHO_T - 4 || cyc > CPU*ECHO_T + 8) begin
      miscompares++; $display("[TB] FAIL stuck_latency: got rdy=%b after %0d cycles want ~%0d", got, cyc, CPU*ECHO_T);
    end
    vectors++;
    if (DIST_MM !== 16'hFFFF || TMO !== 1'b1 || CH_ID !== 3'd2) begin
      miscompares++; $display("[TB] FAIL stuck_result: got dist=%h tmo=%b ch=%0d want FFFF 1 2", DIST_MM, TMO, CH_ID);
    end
`ifdef SR04_SCAN_DONE_EN
    vectors++;
    if (SCAN_DONE !== 1'b1) begin miscompares++; $display("[TB] FAIL stuck_scan_done: got %b want 1", SCAN_DONE); end
`endif
    @(negedge CLK);
    wait_trig_rise(2*CPU*GUARD_T, ch, cyc);
    vectors++;
    if (ch !== 2) begin miscompares++; $display("[TB] FAIL stuck_retrigger: got %0d want 2", ch); end
  endtask

  task automatic test_en_drop();
    int ch, cyc, width;
    bit got, seen;
    apply_reset();
    CH_MASK = 4'b0001; EN = 1'b1;
    wait_trig_rise(100, ch, cyc);
    wait_trig_fall(100, width);
    ECHO[0] = 1'b1;
    repeat (500*CPU) @(negedge CLK);
    EN = 1'b0;
    repeat (1500*CPU) @(negedge CLK);
    ECHO[0] = 1'b0;
    wait_rdy(50, got, cyc);
    vectors++;
    if (got !== 1'b1 || CH_ID !== 3'd0 || TMO !== 1'b0) begin
      miscompares++; $display("[TB] FAIL endrop_rdy: got rdy=%b ch=%0d tmo=%b want 1 0 0", got, CH_ID, TMO);
    end
    vectors++;
    if (DIST_MM < 16'd341 || DIST_MM > 16'd343) begin miscompares++; $display("[TB] FAIL endrop_dist: got %0d want 342+-1", DIST_MM); end
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL endrop_guard_busy: got %b want 1", BUSY); end
    cyc = 0;
    while (BUSY && cyc < 2*CPU*GUARD_T) begin @(negedge CLK); cyc++; end
    vectors++;
    if (BUSY !== 1'b0 || cyc < CPU*GUARD_T - 4) begin
      miscompares++; $display("[TB] FAIL endrop_idle: got busy=%b after %0d cycles want 0 after ~%0d", BUSY, cyc, CPU*GUARD_T);
    end
    seen = 1'b0;
    repeat (1000) begin @(negedge CLK); if (TRIG != 4'b0 || BUSY) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL endrop_no_trig: got activity=%b want 0", seen); end
  endtask

  task automatic test_reset_mid_trig();
    int ch, cyc;
    apply_reset();
    CH_MASK = 4'b0010; EN = 1'b1;
    wait_trig_rise(100, ch, cyc);
    vectors++;
    if (TRIG !== 4'b0010) begin miscompares++; $display("[TB] FAIL rst_pre_trig: got %b want 0010", TRIG); end
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    vectors++;
    if (TRIG !== 4'b0 || BUSY !== 1'b0 || DAT_RDY !== 1'b0 || DIST_MM !== 16'd0 || CH_ID !== 3'd0 || TMO !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_async: got trig=%b busy=%b rdy=%b dist=%0d ch=%0d tmo=%b want all 0",
                              TRIG, BUSY, DAT_RDY, DIST_MM, CH_ID, TMO);
    end
    CH_MASK = 4'b1111;
    @(negedge CLK);
    RST = 1'b0;
    wait_trig_rise(100, ch, cyc);
    vectors++;
    if (ch !== 0) begin miscompares++; $display("[TB] FAIL rst_first_ch: got %0d want 0", ch); end
  endtask

  task automatic test_empty_mask();
    int ch, cyc;
    bit seen;
    apply_reset();
    CH_MASK = 4'b0000; EN = 1'b1;
    seen = 1'b0;
    repeat (100*CPU) begin @(negedge CLK); if (BUSY || TRIG != 4'b0 || DAT_RDY) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_idle: got activity=%b want 0", seen); end
    CH_MASK = 4'b0001;
    wait_trig_rise(10, ch, cyc);
    vectors++;
    if (ch !== 0 || cyc > 2) begin miscompares++; $display("[TB] FAIL empty_start: got ch=%0d after %0d cycles want ch0 within 2", ch, cyc); end
  endtask

  initial begin
    $display("[TB] sr04_scan_scheduler directed bench");
    test_reset();
    test_basic_measure();
    test_timeout_alternate();
    test_stuck_high();
    test_en_drop();
    test_reset_mid_trig();
    test_empty_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
